// File: rtl/trap_ctrl.sv
// Sequences ecall trap entry and mret return between EXU, the CSR file and the IFU redirect path.
// Latency: ecall redirects 2 cycles after accept, mret 4; trap_ready is low until the redirect is taken.
module trap_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int ECALL_CAUSE = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_ecall,
  input  logic                  trap_mret,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  output logic                  trap_ready,
  output logic                  intr,
  output logic [DATA_WIDTH-1:0] intr_NO,
  output logic [DATA_WIDTH-1:0] intr_epc,
  input  logic [DATA_WIDTH-1:0] intr_mtvec,
  output logic                  csr_own,
  output logic [DATA_WIDTH-1:0] csr_addr,
  output logic                  csr_wen,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  redirect_ready
);

  localparam logic [DATA_WIDTH-1:0] ADDR_MEPC    = DATA_WIDTH'(12'h341);
  localparam logic [DATA_WIDTH-1:0] ADDR_MSTATUS = DATA_WIDTH'(12'h300);
  localparam logic [DATA_WIDTH-1:0] CAUSE        = DATA_WIDTH'(ECALL_CAUSE);

  typedef enum logic [2:0] {
    IDLE,
    T_ENT,
    R_EPC,
    R_ST,
    W_ST,
    REDIR
  } state_t;

  state_t                  state, state_nxt;
  logic [DATA_WIDTH-1:0]   epc, tgt, st;
  logic [DATA_WIDTH-1:0]   st_restored;

  // mret restore: MIE <= MPIE, MPIE <= 1, MPP <= M-mode.
  always_comb begin
    st_restored      = st;
    st_restored[3]   = st[7];
    st_restored[7]   = 1'b1;
    st_restored[12:11] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      epc   <= '0;
      tgt   <= '0;
      st    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && trap_ecall) epc <= trap_pc;
      if (state == T_ENT) tgt <= intr_mtvec;
      if (state == R_EPC) tgt <= csr_rdata;
      if (state == R_ST)  st  <= csr_rdata;
    end
  end

  always_comb begin
    state_nxt      = state;
    trap_ready     = 1'b0;
    intr           = 1'b0;
    intr_NO        = '0;
    intr_epc       = '0;
    csr_own        = 1'b0;
    csr_addr       = '0;
    csr_wen        = 1'b0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = tgt;
    case (state)
      IDLE: begin
        trap_ready = 1'b1;
        if (trap_ecall)     state_nxt = T_ENT;
        else if (trap_mret) state_nxt = R_EPC;
      end
      T_ENT: begin
        // No CSR write here: the CSR file would let a write shadow the trap strobe.
        intr      = 1'b1;
        intr_NO   = CAUSE;
        intr_epc  = epc;
        state_nxt = REDIR;
      end
      R_EPC: begin
        csr_own   = 1'b1;
        csr_addr  = ADDR_MEPC;
        state_nxt = R_ST;
      end
      R_ST: begin
        csr_own   = 1'b1;
        csr_addr  = ADDR_MSTATUS;
        state_nxt = W_ST;
      end
      W_ST: begin
        csr_own   = 1'b1;
        csr_addr  = ADDR_MSTATUS;
        csr_wen   = 1'b1;
        csr_wdata = st_restored;
        state_nxt = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a small CSR file model and a redirect-target scoreboard.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_ecall, trap_mret;
  logic [31:0] trap_pc;
  logic        trap_ready;
  logic        intr;
  logic [31:0] intr_NO, intr_epc, intr_mtvec;
  logic        csr_own, csr_wen;
  logic [31:0] csr_addr, csr_wdata, csr_rdata;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;

  // CSR file model state, updated only inside tick()
  logic [31:0] m_mepc, m_mcause, m_mstatus, m_mtvec;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  trap_ctrl #(.DATA_WIDTH(32), .ECALL_CAUSE(11)) dut (
    .clk(clk), .rst(rst),
    .trap_ecall(trap_ecall), .trap_mret(trap_mret), .trap_pc(trap_pc),
    .trap_ready(trap_ready),
    .intr(intr), .intr_NO(intr_NO), .intr_epc(intr_epc), .intr_mtvec(intr_mtvec),
    .csr_own(csr_own), .csr_addr(csr_addr), .csr_wen(csr_wen),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready)
  );

  assign intr_mtvec = m_mtvec;

  always_comb begin
    csr_rdata = '0;
    if (csr_own) begin
      case (csr_addr)
        32'h341: csr_rdata = m_mepc;
        32'h342: csr_rdata = m_mcause;
        32'h300: csr_rdata = m_mstatus;
        32'h305: csr_rdata = m_mtvec;
        default: csr_rdata = '0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: the CSR model commits what the DUT drove during the cycle (write beats trap).
  task automatic tick();
    logic        wen, irq;
    logic [31:0] addr, wdata, epc, cause;
    wen = csr_wen; irq = intr; addr = csr_addr; wdata = csr_wdata;
    epc = intr_epc; cause = intr_NO;
    @(posedge clk);
    if (wen && addr == 32'h341)      m_mepc    = wdata;
    else if (wen && addr == 32'h300) m_mstatus = wdata;
    else if (wen && addr == 32'h342) m_mcause  = wdata;
    else if (irq) begin
      m_mepc   = epc;
      m_mcause = cause;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && redirect_valid && redirect_ready) begin
      if (exp_q.size() == 0) chk("redir_unexpected", 32'h1, 32'h0);
      else chk("redir_pc_sb", redirect_pc, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; trap_ecall = 1'b0; trap_mret = 1'b0; trap_pc = '0;
    redirect_ready = 1'b1;
    m_mepc = '0; m_mcause = '0; m_mstatus = '0; m_mtvec = 32'h8000_0100;

    // 1 reset
    tick(); tick();
    chk("rst_trap_ready", {31'b0, trap_ready}, 32'h1);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    chk("rst_csr_wen", {31'b0, csr_wen}, 32'h0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst_csr_addr", csr_addr, 32'h0);
    rst = 1'b0;
    tick();

    // 2 ecall
    trap_ecall = 1'b1; trap_pc = 32'h8000_0040;
    exp_q.push_back(32'h8000_0100);
    chk("ec_ready_c0", {31'b0, trap_ready}, 32'h1);
    tick(); trap_ecall = 1'b0;
    chk("ec_intr_c1", {31'b0, intr}, 32'h1);
    chk("ec_cause_c1", intr_NO, 32'd11);
    chk("ec_epc_c1", intr_epc, 32'h8000_0040);
    chk("ec_wen_c1", {31'b0, csr_wen}, 32'h0);
    chk("ec_ready_c1", {31'b0, trap_ready}, 32'h0);
    tick();
    chk("ec_rv_c2", {31'b0, redirect_valid}, 32'h1);
    chk("ec_pc_c2", redirect_pc, 32'h8000_0100);
    chk("ec_mepc", m_mepc, 32'h8000_0040);
    chk("ec_mcause", m_mcause, 32'd11);
    tick();
    chk("ec_idle", {31'b0, trap_ready}, 32'h1);

    // 3 mret
    m_mepc = 32'h8000_0044; m_mstatus = 32'h0000_1880;
    trap_mret = 1'b1;
    exp_q.push_back(32'h8000_0044);
    tick(); trap_mret = 1'b0;
    chk("mr_own_c1", {31'b0, csr_own}, 32'h1);
    chk("mr_addr_c1", csr_addr, 32'h341);
    chk("mr_wen_c1", {31'b0, csr_wen}, 32'h0);
    tick();
    chk("mr_addr_c2", csr_addr, 32'h300);
    chk("mr_wen_c2", {31'b0, csr_wen}, 32'h0);
    tick();
    chk("mr_wen_c3", {31'b0, csr_wen}, 32'h1);
    chk("mr_addr_c3", csr_addr, 32'h300);
    chk("mr_wdata_c3", csr_wdata, 32'h0000_1888);
    tick();
    chk("mr_rv_c4", {31'b0, redirect_valid}, 32'h1);
    chk("mr_pc_c4", redirect_pc, 32'h8000_0044);
    chk("mr_mstatus", m_mstatus, 32'h0000_1888);
    tick();

    // 4 ecall+mret together: ecall first, then mret returns to the epc ecall just wrote
    trap_ecall = 1'b1; trap_mret = 1'b1; trap_pc = 32'h8000_0080;
    exp_q.push_back(32'h8000_0100);
    exp_q.push_back(32'h8000_0080);
    tick(); trap_ecall = 1'b0;
    chk("both_intr", {31'b0, intr}, 32'h1);
    chk("both_own", {31'b0, csr_own}, 32'h0);
    tick();
    chk("both_pc1", redirect_pc, 32'h8000_0100);
    tick();
    chk("both_idle", {31'b0, trap_ready}, 32'h1);
    tick(); trap_mret = 1'b0;
    chk("both_mret_addr", csr_addr, 32'h341);
    tick(); tick(); tick();
    chk("both_pc2", redirect_pc, 32'h8000_0080);
    tick();

    // 5 redirect stall, with an mret held that must not be accepted
    m_mtvec = 32'h8000_0203;
    redirect_ready = 1'b0;
    trap_ecall = 1'b1; trap_pc = 32'h8000_0090;
    exp_q.push_back(32'h8000_0203);
    tick(); trap_ecall = 1'b0; trap_mret = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("st_rv", {31'b0, redirect_valid}, 32'h1);
      chk("st_pc", redirect_pc, 32'h8000_0203);
      chk("st_ready", {31'b0, trap_ready}, 32'h0);
      chk("st_own", {31'b0, csr_own}, 32'h0);
    end
    trap_mret = 1'b0; redirect_ready = 1'b1;
    tick();
    chk("st_idle", {31'b0, trap_ready}, 32'h1);
    chk("st_rv_off", {31'b0, redirect_valid}, 32'h0);

    // 6 reset mid-mret
    m_mstatus = 32'h0000_0008;
    trap_mret = 1'b1;
    tick(); trap_mret = 1'b0;
    tick();
    chk("rr_in_rst", csr_addr, 32'h300);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rr_ready", {31'b0, trap_ready}, 32'h1);
    chk("rr_wen", {31'b0, csr_wen}, 32'h0);
    chk("rr_own", {31'b0, csr_own}, 32'h0);
    tick(); tick();
    chk("rr_wen_later", {31'b0, csr_wen}, 32'h0);
    chk("rr_mstatus", m_mstatus, 32'h0000_0008);
    chk("rr_rv", {31'b0, redirect_valid}, 32'h0);

    chk("sb_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
